// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the 64x32 register file and its
//   writeback queue front end.
//
//   REG_AW     register address width (64 registers)
//   REG_DW     register data width
//   NUM_REGS   number of architectural registers
//   wb_entry_t one pending writeback: destination register plus result data
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_AW   = 6;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 64;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_match.sv
// -----------------------------------------------------------------------------
// regfile_wb_match
//   Combinational newest-first forwarding lookup over the writeback queue
//   entries and the register file output stage.
//
//   Ports:
//     addr       in   register being looked up
//     ent_valid  in   per-slot valid, slot 0 oldest .. slot DEPTH-1 newest
//     ent_rd     in   per-slot destination register (same age order)
//     ent_data   in   per-slot data (same age order)
//     out_valid  in   output stage holds a write this cycle (wrt)
//     out_rd     in   output stage destination register
//     out_data   in   output stage data
//     hit        out  some pending or in-flight write targets addr
//     fwd        out  newest matching data, 0 when hit is 0
// -----------------------------------------------------------------------------
module regfile_wb_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic [AW-1:0]             addr,
  input  logic [DEPTH-1:0]          ent_valid,
  input  logic [DEPTH-1:0][AW-1:0]  ent_rd,
  input  logic [DEPTH-1:0][DW-1:0]  ent_data,
  input  logic                      out_valid,
  input  logic [AW-1:0]             out_rd,
  input  logic [DW-1:0]             out_data,
  output logic                      hit,
  output logic [DW-1:0]             fwd
);

  // Scan from oldest (output stage) to newest queue slot; each later match
  // overrides the earlier one, so the youngest writer wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment;
    // leaving a path unassigned in combinational logic infers a latch.
    hit = 1'b0;
    fwd = '0;
    if (out_valid && (out_rd == addr)) begin
      hit = 1'b1;
      fwd = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == addr)) begin
        hit = 1'b1;
        fwd = ent_data[i];
      end
    end
  end

endmodule : regfile_wb_match

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Writer-side front end for the 64x32 register file. Writeback results are
//   accepted into an in-order queue and drained one per cycle onto the
//   register file write port (wrt/rd/datain), which the register file samples
//   on the following negedge. Two combinational lookups (rs, rt) report the
//   newest pending value for a register, covering the queue and the output
//   stage.
//
//   Ports:
//     clk, rst            clock; synchronous active-high reset
//     in_valid/in_ready   writeback handshake (in_ready == !full)
//     in_rd, in_data      writeback destination and data
//     hold                suppress draining (queue still accepts)
//     wrt, rd, datain     registered register file write port
//     q_rs -> rs_hit/rs_fwd   forwarding lookup A
//     q_rt -> rt_hit/rt_fwd   forwarding lookup B
//     count, empty, full  queue occupancy (output stage not included)
// -----------------------------------------------------------------------------
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,        // power of two, >= 2
  parameter int AW    = REG_AW,   // must match wb_entry_t field widths
  parameter int DW    = REG_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [DW-1:0]              in_data,
  input  logic                       hold,
  output logic                       wrt,
  output logic [AW-1:0]              rd,
  output logic [DW-1:0]              datain,
  input  logic [AW-1:0]              q_rs,
  output logic                       rs_hit,
  output logic [DW-1:0]              rs_fwd,
  input  logic [AW-1:0]              q_rt,
  output logic                       rt_hit,
  output logic [DW-1:0]              rt_fwd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

  // No bypass when full: a same-cycle drain does not open a slot until the
  // edge, so a request arriving while full is simply held off.
  assign push = in_valid && in_ready;
  assign pop  = !empty && !hold;

  // NOTE: the storage array has no reset. Only the pointers and count
  // define which slots are live, so clearing them discards every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: in_rd, data: in_data};
    end
  end

  // Pointers, occupancy and the registered register file write port.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wrt    <= 1'b0;
      rd     <= '0;
      datain <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        wrt    <= 1'b1;
        rd     <= mem[rd_ptr].rd;
        datain <= mem[rd_ptr].data;
      end else begin
        // rd/datain keep their last values; only the enable drops.
        wrt <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Present the live queue slots to the matchers in age order
  // (slot 0 = head/oldest). Slots beyond count are masked off.
  logic [DEPTH-1:0]         age_valid;
  logic [DEPTH-1:0][AW-1:0] age_rd;
  logic [DEPTH-1:0][DW-1:0] age_data;

  always_comb begin
    age_valid = '0;
    age_rd    = '0;
    age_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_valid[i] = (CW'(i) < count);
      age_rd[i]    = mem[rd_ptr + PW'(i)].rd;
      age_data[i]  = mem[rd_ptr + PW'(i)].data;
    end
  end

  regfile_wb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match_rs (
    .addr      (q_rs),
    .ent_valid (age_valid),
    .ent_rd    (age_rd),
    .ent_data  (age_data),
    .out_valid (wrt),
    .out_rd    (rd),
    .out_data  (datain),
    .hit       (rs_hit),
    .fwd       (rs_fwd)
  );

  regfile_wb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match_rt (
    .addr      (q_rt),
    .ent_valid (age_valid),
    .ent_rd    (age_rd),
    .ent_data  (age_data),
    .out_valid (wrt),
    .out_rd    (rd),
    .out_data  (datain),
    .hit       (rt_hit),
    .fwd       (rt_fwd)
  );

endmodule : regfile_wb_queue
